alu_op_sequencer: RTL and testbench

//  Multi-cycle controller that sequences the single-cycle MIPS alu for one instruction at a time.
//  Per instruction it:
//   - accepts the instruction on a valid/ready command port;
//   - reads rs and rt from the register file over one shared synchronous read port;
//   - drives the alu with operands remapped onto its regA/regB inputs;
//   - writes the result back and returns result plus flags on a response port.

---
 rtl/alu_op_sequencer.sv | 128 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Sequences one instruction at a time through a shared 1-cycle register-file read port and a combinational alu.
// Latency: accept at edge 0, rf_we in cycle 4, rsp_valid from cycle 5; one instruction every 6 cycles.
// Backpressure: cmd_ready only in IDLE; response held stable in RESP until rsp_ready.
module alu_op_sequencer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_instr,
    output logic [4:0]       rf_raddr,
    input  logic [31:0]      rf_rdata,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [31:0]      rf_wdata,
    output logic [31:0]      alu_instr,
    output logic [31:0]      alu_regA,
    output logic [31:0]      alu_regB,
    input  logic [31:0]      alu_result,
    input  logic [2:0]       alu_flags,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic [2:0]       rsp_flags,
    output logic [2:0]       sticky_flags,
    input  logic             flags_clr,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        EXEC = 3'd3,
        WB   = 3'd4,
        RESP = 3'd5
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] instr_q;
    logic [31:0] op_a;
    logic [4:0]  dest;
    logic        rsp_accept;

    assign rsp_accept = (state == RESP) && rsp_ready;
    // R-type writes rd, I-type writes rt
    assign dest       = (instr_q[31:26] == 6'd0) ? instr_q[15:11] : instr_q[20:16];
    assign rf_waddr   = dest;
    assign rf_wdata   = rsp_result;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q      <= '0;
            op_a         <= '0;
            rsp_result   <= '0;
            rsp_flags    <= '0;
            sticky_flags <= '0;
            op_count     <= '0;
        end else begin
            if (state == IDLE && cmd_valid) begin
                instr_q <= cmd_instr;
            end
            if (state == RD_B) begin
                op_a <= rf_rdata;
            end
            if (state == EXEC) begin
                rsp_result <= alu_result;
                rsp_flags  <= alu_flags;
            end
            if (rsp_accept) begin
                op_count <= op_count + CNT_W'(1);
            end
            // A coincident clear beats the accumulate
            if (flags_clr) begin
                sticky_flags <= '0;
            end else if (rsp_accept) begin
                sticky_flags <= sticky_flags | rsp_flags;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = RD_A;
            RD_A:    state_nxt = RD_B;
            RD_B:    state_nxt = EXEC;
            EXEC:    state_nxt = WB;
            WB:      state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        rf_raddr  = '0;
        alu_instr = '0;
        alu_regA  = '0;
        alu_regB  = '0;
        rf_we     = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: cmd_ready = 1'b1;
            RD_A: rf_raddr = instr_q[25:21];
            RD_B: rf_raddr = instr_q[20:16];
            EXEC: begin
                // Fixed rs=0/rt=1 fields steer the alu to regA/regB even when rs==rt
                alu_instr = {instr_q[31:26], 5'd0, 5'd1, instr_q[15:0]};
                alu_regA  = op_a;
                alu_regB  = rf_rdata;
            end
            WB:   rf_we = (dest != 5'd0);
            RESP: rsp_valid = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural register file and alu.
module tb_alu_op_sequencer;

    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [31:0]      cmd_instr;
    logic [4:0]       rf_raddr;
    logic [31:0]      rf_rdata;
    logic             rf_we;
    logic [4:0]       rf_waddr;
    logic [31:0]      rf_wdata;
    logic [31:0]      alu_instr;
    logic [31:0]      alu_regA;
    logic [31:0]      alu_regB;
    logic [31:0]      alu_result;
    logic [2:0]       alu_flags;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic [2:0]       rsp_flags;
    logic [2:0]       sticky_flags;
    logic             flags_clr;
    logic [CNT_W-1:0] op_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] rf [32];
    logic        pre_we;
    logic [4:0]  pre_addr;
    logic [31:0] pre_data;

    always #5 clk = ~clk;

    alu_op_sequencer #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_instr(cmd_instr),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .alu_instr(alu_instr), .alu_regA(alu_regA), .alu_regB(alu_regB),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .sticky_flags(sticky_flags), .flags_clr(flags_clr), .op_count(op_count)
    );

    always @(posedge clk) begin
        rf_rdata <= rf[rf_raddr];
        if (pre_we) rf[pre_addr] <= pre_data;
        else if (rf_we) rf[rf_waddr] <= rf_wdata;
    end

    // Small alu: addu / subu / addiu, flags {zero, negative, overflow}
    always_comb begin
        alu_result = 32'd0;
        case (alu_instr[31:26])
            6'h00: begin
                if (alu_instr[5:0] == 6'h21) alu_result = alu_regA + alu_regB;
                else if (alu_instr[5:0] == 6'h23) alu_result = alu_regA - alu_regB;
            end
            6'h09: alu_result = alu_regA + {{16{alu_instr[15]}}, alu_instr[15:0]};
            default: alu_result = 32'd0;
        endcase
        alu_flags = {alu_result == 32'd0, alu_result[31], 1'b0};
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        tick();
        pre_we = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL reset_rf_we: got %b want 0", rf_we); end
        n_cmp++; if (rsp_result !== 32'd0) begin n_err++; $display("FAIL reset_rsp_result: got %h want 0", rsp_result); end
        n_cmp++; if (rsp_flags !== 3'd0) begin n_err++; $display("FAIL reset_rsp_flags: got %b want 000", rsp_flags); end
        n_cmp++; if (sticky_flags !== 3'd0) begin n_err++; $display("FAIL reset_sticky: got %b want 000", sticky_flags); end
        n_cmp++; if (op_count !== 2'd0) begin n_err++; $display("FAIL reset_op_count: got %0d want 0", op_count); end
        n_cmp++; if (rf_raddr !== 5'd0 || alu_instr !== 32'd0 || alu_regA !== 32'd0 || alu_regB !== 32'd0)
            begin n_err++; $display("FAIL reset_idle_outs: got raddr %0d instr %h A %h B %h want all 0", rf_raddr, alu_instr, alu_regA, alu_regB); end
    endtask

    task automatic test_addu();
        preload(5'd2, 32'd5);
        preload(5'd3, 32'd7);
        cmd_instr = 32'h00432021; cmd_valid = 1'b1; rsp_ready = 1'b1;
        tick(); cmd_valid = 1'b0;
        n_cmp++; if (rf_raddr !== 5'd2) begin n_err++; $display("FAIL addu_raddr_rs: got %0d want 2", rf_raddr); end
        n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL addu_cmd_ready_busy: got %b want 0", cmd_ready); end
        tick();
        n_cmp++; if (rf_raddr !== 5'd3) begin n_err++; $display("FAIL addu_raddr_rt: got %0d want 3", rf_raddr); end
        tick();
        n_cmp++; if (alu_instr !== 32'h00012021) begin n_err++; $display("FAIL addu_alu_instr: got %h want 00012021", alu_instr); end
        n_cmp++; if (alu_regA !== 32'd5 || alu_regB !== 32'd7) begin n_err++; $display("FAIL addu_operands: got %h/%h want 5/7", alu_regA, alu_regB); end
        n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL addu_early_we: got %b want 0", rf_we); end
        tick();
        n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'd12)
            begin n_err++; $display("FAIL addu_writeback: got we %b addr %0d data %0d want 1/4/12", rf_we, rf_waddr, rf_wdata); end
        tick();
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_result !== 32'd12 || rsp_flags !== 3'b000)
            begin n_err++; $display("FAIL addu_rsp: got v %b res %0d fl %b want 1/12/000", rsp_valid, rsp_result, rsp_flags); end
        n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL addu_we_after_wb: got %b want 0", rf_we); end
        tick();
        n_cmp++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || op_count !== 2'd1)
            begin n_err++; $display("FAIL addu_done: got v %b rdy %b cnt %0d want 0/1/1", rsp_valid, cmd_ready, op_count); end
    endtask

    task automatic test_addiu();
        preload(5'd1, 32'hFFFF_FFFF);
        preload(5'd5, 32'h55);
        cmd_instr = 32'h24250001; cmd_valid = 1'b1;
        tick(); cmd_valid = 1'b0;
        n_cmp++; if (rf_raddr !== 5'd1) begin n_err++; $display("FAIL addiu_raddr_rs: got %0d want 1", rf_raddr); end
        tick(); tick();
        n_cmp++; if (alu_instr !== 32'h24010001) begin n_err++; $display("FAIL addiu_alu_instr: got %h want 24010001", alu_instr); end
        n_cmp++; if (alu_regA !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL addiu_regA: got %h want ffffffff", alu_regA); end
        tick();
        n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'd0)
            begin n_err++; $display("FAIL addiu_writeback: got we %b addr %0d data %h want 1/5/0", rf_we, rf_waddr, rf_wdata); end
        tick();
        n_cmp++; if (rsp_result !== 32'd0 || rsp_flags !== 3'b100)
            begin n_err++; $display("FAIL addiu_rsp: got res %h fl %b want 0/100", rsp_result, rsp_flags); end
        tick();
        n_cmp++; if (sticky_flags !== 3'b100 || op_count !== 2'd2)
            begin n_err++; $display("FAIL addiu_done: got sticky %b cnt %0d want 100/2", sticky_flags, op_count); end
    endtask

    task automatic test_dest_zero();
        cmd_instr = 32'h00430021; cmd_valid = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick(); cmd_valid = 1'b0;
            n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL zero_dest_we c%0d: got %b want 0", c, rf_we); end
        end
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_result !== 32'd12)
            begin n_err++; $display("FAIL zero_dest_rsp: got v %b res %0d want 1/12", rsp_valid, rsp_result); end
        tick();
        n_cmp++; if (op_count !== 2'd3 || sticky_flags !== 3'b100)
            begin n_err++; $display("FAIL zero_dest_done: got cnt %0d sticky %b want 3/100", op_count, sticky_flags); end
    endtask

    task automatic test_backpressure();
        cmd_instr = 32'h00633021; cmd_valid = 1'b1; rsp_ready = 1'b0;
        tick(); cmd_valid = 1'b0;
        tick(); tick();
        n_cmp++; if (alu_instr !== 32'h00013021 || alu_regA !== 32'd7 || alu_regB !== 32'd7)
            begin n_err++; $display("FAIL bp_rs_eq_rt: got %h A %0d B %0d want 00013021/7/7", alu_instr, alu_regA, alu_regB); end
        tick();
        n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd6 || rf_wdata !== 32'd14)
            begin n_err++; $display("FAIL bp_writeback: got we %b addr %0d data %0d want 1/6/14", rf_we, rf_waddr, rf_wdata); end
        tick();
        cmd_instr = 32'h00432021; cmd_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_cmp++; if (rsp_valid !== 1'b1 || rsp_result !== 32'd14 || cmd_ready !== 1'b0)
                begin n_err++; $display("FAIL bp_hold c%0d: got v %b res %0d rdy %b want 1/14/0", c, rsp_valid, rsp_result, cmd_ready); end
        end
        rsp_ready = 1'b1;
        tick();
        n_cmp++; if (cmd_ready !== 1'b1 || op_count !== 2'd0)
            begin n_err++; $display("FAIL bp_release: got rdy %b cnt %0d want 1/0", cmd_ready, op_count); end
        tick(); cmd_valid = 1'b0;
        n_cmp++; if (rf_raddr !== 5'd2) begin n_err++; $display("FAIL bp_next_accept: got raddr %0d want 2", rf_raddr); end
        repeat (4) tick();
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_result !== 32'd12)
            begin n_err++; $display("FAIL bp_next_rsp: got v %b res %0d want 1/12", rsp_valid, rsp_result); end
        tick();
        n_cmp++; if (op_count !== 2'd1) begin n_err++; $display("FAIL bp_next_count: got %0d want 1", op_count); end
    endtask

    task automatic test_reset_mid_op();
        preload(5'd7, 32'h77);
        cmd_instr = 32'h00433821; cmd_valid = 1'b1;
        tick(); cmd_valid = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick(); reset = 1'b0;
        n_cmp++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rf_we !== 1'b0)
            begin n_err++; $display("FAIL rst_exec_state: got rdy %b v %b we %b want 1/0/0", cmd_ready, rsp_valid, rf_we); end
        n_cmp++; if (op_count !== 2'd0 || rsp_result !== 32'd0 || sticky_flags !== 3'd0)
            begin n_err++; $display("FAIL rst_exec_regs: got cnt %0d res %h sticky %b want 0/0/000", op_count, rsp_result, sticky_flags); end
        for (int c = 0; c < 6; c++) begin
            tick();
            n_cmp++; if (rf_we !== 1'b0 || rsp_valid !== 1'b0)
                begin n_err++; $display("FAIL rst_exec_quiet c%0d: got we %b v %b want 0/0", c, rf_we, rsp_valid); end
        end
        n_cmp++; if (rf[7] !== 32'h77) begin n_err++; $display("FAIL rst_exec_no_write: got r7 %h want 77", rf[7]); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        logic       exp_rdy;
        logic       exp_we;
        rsp_ready = 1'b1;
        cmd_instr = 32'h00432021; cmd_valid = 1'b1;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL b2b_start_ready: got %b want 1", cmd_ready); end
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 30) cmd_valid = 1'b0;
            exp_rdy = (k % 6 == 0);
            exp_we  = (k % 6 == 4);
            n_cmp++; if (cmd_ready !== exp_rdy) begin n_err++; $display("FAIL b2b_ready k%0d: got %b want %b", k, cmd_ready, exp_rdy); end
            n_cmp++; if (rf_we !== exp_we) begin n_err++; $display("FAIL b2b_we k%0d: got %b want %b", k, rf_we, exp_we); end
            if (k % 6 == 0) begin
                n_cmp++; if (op_count !== exp_cnt[k/6-1])
                    begin n_err++; $display("FAIL b2b_count op%0d: got %0d want %0d", k/6, op_count, exp_cnt[k/6-1]); end
            end
        end
    endtask

    task automatic test_flags_clr();
        cmd_instr = 32'h00434023; cmd_valid = 1'b1;
        tick(); cmd_valid = 1'b0;
        repeat (4) tick();
        n_cmp++; if (rsp_result !== 32'hFFFF_FFFE || rsp_flags !== 3'b010)
            begin n_err++; $display("FAIL clr_subu_rsp: got res %h fl %b want fffffffe/010", rsp_result, rsp_flags); end
        tick();
        n_cmp++; if (sticky_flags !== 3'b010 || op_count !== 2'd2)
            begin n_err++; $display("FAIL clr_accumulate: got sticky %b cnt %0d want 010/2", sticky_flags, op_count); end
        cmd_instr = 32'h24250001; cmd_valid = 1'b1;
        tick(); cmd_valid = 1'b0;
        repeat (4) tick();
        n_cmp++; if (rsp_flags !== 3'b100 || sticky_flags !== 3'b010)
            begin n_err++; $display("FAIL clr_before: got fl %b sticky %b want 100/010", rsp_flags, sticky_flags); end
        flags_clr = 1'b1;
        tick(); flags_clr = 1'b0;
        n_cmp++; if (sticky_flags !== 3'b000 || op_count !== 2'd3)
            begin n_err++; $display("FAIL clr_coincident: got sticky %b cnt %0d want 000/3", sticky_flags, op_count); end
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_instr = 32'd0; rsp_ready = 1'b1; flags_clr = 1'b0;
        pre_we = 1'b0; pre_addr = 5'd0; pre_data = 32'd0;
        test_reset();
        test_addu();
        test_addiu();
        test_dest_zero();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        test_flags_clr();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
